// File: rtl/l2cache_control.sv
// L2 cache controller FSM: hit check, dirty write-back and line refill sequencing.
// Defining L2_PERF_CNT_EN adds saturating hit/miss performance counters.
module l2cache_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp,
  input  logic        hit,
  input  logic        dirty,
  input  logic        valid,
  input  logic        valid_lru_way,
  output logic        way_sel_method,
  output logic        load_line_data,
  output logic        load_valid,
  output logic        load_wdata_reg,
  output logic        load_dirty,
  output logic        load_LRU,
  output logic        line_datain_sel,
  output logic        valid_in,
  output logic        dirty_in,
  output logic        address_sel,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CHECK      = 2'd1;
  localparam logic [1:0] WRITE_BACK = 2'd2;
  localparam logic [1:0] ALLOCATE   = 2'd3;

  logic [1:0] state_q, state_d;

  // The victim decision only needs valid_lru_way; the hit-way valid bit is carried for the datapath.
  logic unusedValid;
  assign unusedValid = valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are forced low while reset is asserted, even before the state register has cleared.
  always_comb begin
    state_d         = state_q;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    way_sel_method  = 1'b0;
    load_line_data  = 1'b0;
    load_valid      = 1'b0;
    load_wdata_reg  = 1'b0;
    load_dirty      = 1'b0;
    load_LRU        = 1'b0;
    line_datain_sel = 1'b0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    address_sel     = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) state_d = CHECK;
        end
        CHECK: begin
          if (hit) begin
            mem_resp = 1'b1;
            load_LRU = 1'b1;
            // A simultaneous read and write is serviced as a write.
            if (mem_write) begin
              load_line_data  = 1'b1;
              line_datain_sel = 1'b1;
              load_dirty      = 1'b1;
              dirty_in        = 1'b1;
              load_valid      = 1'b1;
              valid_in        = 1'b1;
            end
            state_d = IDLE;
          end else if (valid_lru_way && dirty) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
        WRITE_BACK: begin
          pmem_write     = 1'b1;
          address_sel    = 1'b1;
          way_sel_method = 1'b1;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read      = 1'b1;
          way_sel_method = 1'b1;
          if (pmem_resp) begin
            load_line_data = 1'b1;
            load_valid     = 1'b1;
            valid_in       = 1'b1;
            load_dirty     = 1'b1;
            state_d        = CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;

  // Every CHECK either hits (and returns to IDLE) or misses, so each CHECK bumps exactly one counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == CHECK) begin
      if (hit && (hit_count_q != 32'hFFFF_FFFF))
        hit_count_q <= hit_count_q + 32'd1;
      if (!hit && (miss_count_q != 32'hFFFF_FFFF))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = rst ? 32'd0 : hit_count_q;
  assign miss_count = rst ? 32'd0 : miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
